// File: rtl/thresholding_axilite_loader_pkg.sv
// rtl/thresholding_axilite_loader_pkg.sv - shared types and threshold address helper for the loader
//
// Contents:
//   state_t   : loader FSM states
//   RESP_OKAY : AXI-Lite OKAY response code
//   WSTRB_ALL : full-word write strobe
//   thr_addr  : byte address of threshold t of channel c in a thresholding core
//               with output precision n and parallelism pe

package thresholding_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_ADVANCE
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [3:0] WSTRB_ALL = 4'hF;

  // The core splits a channel into (fold, lane) = (c / pe, c % pe); the lane
  // field sits between the fold and the threshold index, and the whole word
  // index is shifted up by 2 to form a byte address.
  function automatic logic [31:0] thr_addr(input int unsigned c, input int unsigned t,
                                           input int unsigned n, input int unsigned pe);
    int unsigned pe_bits;
    int unsigned cf;
    int unsigned lane;
    pe_bits = $clog2(pe);
    cf      = c / pe;
    lane    = c % pe;
    return ((((cf << pe_bits) | lane) << n) | t) << 2;
  endfunction

endpackage

// File: rtl/thresholding_axilite_loader.sv
// rtl/thresholding_axilite_loader.sv - AXI-Lite initiator that writes a threshold stream into a thresholding core
//
// Ports:
//   ap_clk, ap_rst             : clock, synchronous active-high reset
//   start, busy, done, error   : load control / status (error sticky until next start)
//   s_axis_*                   : incoming threshold words, channel-major order
//   m_axilite_AW*/W*/B*        : write channels towards the core's responder port
//   m_axilite_AR*/R*           : readback channels, active only when VERIFY = 1

module thresholding_axilite_loader
  import thresholding_loader_pkg::*;
#(
  parameter int N      = 4,
  parameter int K      = 9,
  parameter int C      = 6,
  parameter int PE     = 2,
  parameter int VERIFY = 0,
  localparam int CF        = C / PE,
  localparam int ADDR_BITS = $clog2(CF) + $clog2(PE) + N + 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tvalid,
  input  logic [31:0]          s_axis_tdata,
  output logic                 m_axilite_AWVALID,
  input  logic                 m_axilite_AWREADY,
  output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
  output logic                 m_axilite_WVALID,
  input  logic                 m_axilite_WREADY,
  output logic [31:0]          m_axilite_WDATA,
  output logic [3:0]           m_axilite_WSTRB,
  input  logic                 m_axilite_BVALID,
  output logic                 m_axilite_BREADY,
  input  logic [1:0]           m_axilite_BRESP,
  output logic                 m_axilite_ARVALID,
  input  logic                 m_axilite_ARREADY,
  output logic [ADDR_BITS-1:0] m_axilite_ARADDR,
  input  logic                 m_axilite_RVALID,
  output logic                 m_axilite_RREADY,
  input  logic [31:0]          m_axilite_RDATA,
  input  logic [1:0]           m_axilite_RRESP
);

  localparam int TCOUNT = (1 << N) - 1;
  localparam int CW     = (C > 1) ? $clog2(C) : 1;
  localparam logic [N-1:0]  LAST_T = N'(TCOUNT - 1);
  localparam logic [CW-1:0] LAST_C = CW'(C - 1);

  state_t        state, state_next;
  logic [31:0]   data_q;
  logic [CW-1:0] c_cnt;
  logic [N-1:0]  t_cnt;
  logic          aw_ok, w_ok;
  logic          error_q, done_q;

  logic aw_hs, w_hs, last_item, rd_mismatch;
  logic unused_rdata;

  assign aw_hs       = m_axilite_AWVALID & m_axilite_AWREADY;
  assign w_hs        = m_axilite_WVALID & m_axilite_WREADY;
  assign last_item   = (c_cnt == LAST_C) && (t_cnt == LAST_T);
  assign rd_mismatch = m_axilite_RDATA[K-1:0] != data_q[K-1:0];

  // Only the low K bits of readback are compared; the rest is don't-care.
  assign unused_rdata = ^m_axilite_RDATA;

  // Read and write target the same location, so both share one address.
  assign m_axilite_AWADDR = ADDR_BITS'(thr_addr(32'(c_cnt), 32'(t_cnt), N, PE));
  assign m_axilite_ARADDR = m_axilite_AWADDR;
  assign m_axilite_WDATA  = data_q;
  assign m_axilite_WSTRB  = WSTRB_ALL;

  assign busy  = (state != S_IDLE);
  assign done  = done_q;
  assign error = error_q;

  always_comb begin
    state_next        = state;
    s_axis_tready     = 1'b0;
    m_axilite_AWVALID = 1'b0;
    m_axilite_WVALID  = 1'b0;
    m_axilite_BREADY  = 1'b0;
    m_axilite_ARVALID = 1'b0;
    m_axilite_RREADY  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_next = S_WRITE;
      end
      S_WRITE: begin
        // AW and W complete independently; leave once both are done,
        // counting a handshake happening in this very cycle.
        m_axilite_AWVALID = ~aw_ok;
        m_axilite_WVALID  = ~w_ok;
        if ((aw_ok | aw_hs) && (w_ok | w_hs)) state_next = S_WRESP;
      end
      S_WRESP: begin
        m_axilite_BREADY = 1'b1;
        if (m_axilite_BVALID) state_next = (VERIFY != 0) ? S_RADDR : S_ADVANCE;
      end
      S_RADDR: begin
        m_axilite_ARVALID = (VERIFY != 0);
        if (m_axilite_ARREADY) state_next = S_RDATA;
      end
      S_RDATA: begin
        m_axilite_RREADY = (VERIFY != 0);
        if (m_axilite_RVALID) state_next = S_ADVANCE;
      end
      S_ADVANCE: begin
        state_next = last_item ? S_IDLE : S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= S_IDLE;
      c_cnt   <= '0;
      t_cnt   <= '0;
      data_q  <= '0;
      aw_ok   <= 1'b0;
      w_ok    <= 1'b0;
      error_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            c_cnt   <= '0;
            t_cnt   <= '0;
            error_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (s_axis_tvalid) begin
            data_q <= s_axis_tdata;
            aw_ok  <= 1'b0;
            w_ok   <= 1'b0;
          end
        end
        S_WRITE: begin
          if (aw_hs) aw_ok <= 1'b1;
          if (w_hs)  w_ok  <= 1'b1;
        end
        S_WRESP: begin
          if (m_axilite_BVALID && (m_axilite_BRESP != RESP_OKAY)) error_q <= 1'b1;
        end
        S_RDATA: begin
          if (m_axilite_RVALID && ((m_axilite_RRESP != RESP_OKAY) || rd_mismatch))
            error_q <= 1'b1;
        end
        S_ADVANCE: begin
          // done is registered so it appears in the first IDLE cycle,
          // when busy has already dropped.
          if (last_item) begin
            done_q <= 1'b1;
          end else if (t_cnt == LAST_T) begin
            t_cnt <= '0;
            c_cnt <= c_cnt + 1'b1;
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_thresholding_axilite_loader.sv
// tb/tb_thresholding_axilite_loader.sv - scoreboard bench for the threshold loader (VERIFY=0 and VERIFY=1 instances)

module tb_thresholding_axilite_loader;

  localparam int N  = 2;
  localparam int K  = 9;
  localparam int C  = 4;
  localparam int PE = 2;
  localparam int AB = 6;
  localparam int TC = 3;
  localparam int NW = C * TC;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]  start;
  logic [1:0]  tvalid;
  logic [31:0] tdata [2];

  wire [1:0] tready, busy, done, error;
  wire [1:0] awvalid, awready, wvalid, wready, bvalid, bready;
  wire [1:0] arvalid, arready, rvalid, rready;
  wire [AB-1:0] awaddr [2];
  wire [AB-1:0] araddr [2];
  wire [31:0]   wdata  [2];
  wire [31:0]   rdata  [2];
  wire [3:0]    wstrb  [2];
  wire [1:0]    bresp  [2];
  wire [1:0]    rresp  [2];

  // responder knobs
  int          aw_wait  [2];
  int          err_idx  [2];
  int          cor_idx  [2];
  logic [31:0] cor_mask [2];

  // responder state
  int          aw_cnt [2];
  logic        have_aw [2];
  logic        have_w  [2];
  logic        have_ar [2];
  logic [AB-1:0] aw_a [2];
  logic [AB-1:0] ar_a [2];
  logic [31:0] w_d [2];
  int          wr_n [2];
  int          rd_n [2];
  logic [31:0] mem [2][16];

  // scoreboard / monitor state
  logic [63:0] exp_q [2][$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int done_cnt [2];
  int b_cnt [2];
  int b_first [2];
  int b_last [2];
  int aw_len [2];
  int w_len [2];
  int aw_len_last [2];
  int w_len_last [2];
  logic [AB-1:0] last_aw [2];
  logic [31:0]   last_w [2];
  logic          prev_awv [2];
  logic          prev_wv [2];
  logic [AB-1:0] prev_awaddr [2];
  logic [31:0]   prev_wdata [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gen
    thresholding_axilite_loader #(.N(N), .K(K), .C(C), .PE(PE), .VERIFY(g)) dut (
      .ap_clk            (clk),
      .ap_rst            (rst),
      .start             (start[g]),
      .busy              (busy[g]),
      .done              (done[g]),
      .error             (error[g]),
      .s_axis_tready     (tready[g]),
      .s_axis_tvalid     (tvalid[g]),
      .s_axis_tdata      (tdata[g]),
      .m_axilite_AWVALID (awvalid[g]),
      .m_axilite_AWREADY (awready[g]),
      .m_axilite_AWADDR  (awaddr[g]),
      .m_axilite_WVALID  (wvalid[g]),
      .m_axilite_WREADY  (wready[g]),
      .m_axilite_WDATA   (wdata[g]),
      .m_axilite_WSTRB   (wstrb[g]),
      .m_axilite_BVALID  (bvalid[g]),
      .m_axilite_BREADY  (bready[g]),
      .m_axilite_BRESP   (bresp[g]),
      .m_axilite_ARVALID (arvalid[g]),
      .m_axilite_ARREADY (arready[g]),
      .m_axilite_ARADDR  (araddr[g]),
      .m_axilite_RVALID  (rvalid[g]),
      .m_axilite_RREADY  (rready[g]),
      .m_axilite_RDATA   (rdata[g]),
      .m_axilite_RRESP   (rresp[g])
    );

    assign awready[g] = awvalid[g] && (aw_cnt[g] >= aw_wait[g]);
    assign wready[g]  = wvalid[g];
    assign bvalid[g]  = have_aw[g] && have_w[g];
    assign bresp[g]   = (wr_n[g] == err_idx[g]) ? 2'b10 : 2'b00;
    assign arready[g] = arvalid[g];
    assign rvalid[g]  = have_ar[g];
    assign rdata[g]   = mem[g][ar_a[g][AB-1:2]] ^ ((rd_n[g] == cor_idx[g]) ? cor_mask[g] : 32'h0);
    assign rresp[g]   = 2'b00;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        aw_cnt[i]  <= 0;
        have_aw[i] <= 1'b0;
        have_w[i]  <= 1'b0;
        have_ar[i] <= 1'b0;
        wr_n[i]    <= 0;
        rd_n[i]    <= 0;
      end else begin
        if (start[i]) begin
          wr_n[i] <= 0;
          rd_n[i] <= 0;
        end
        if (awvalid[i] && awready[i]) begin
          aw_cnt[i]  <= 0;
          have_aw[i] <= 1'b1;
          aw_a[i]    <= awaddr[i];
        end else if (awvalid[i]) begin
          aw_cnt[i] <= aw_cnt[i] + 1;
        end
        if (wvalid[i] && wready[i]) begin
          have_w[i] <= 1'b1;
          w_d[i]    <= wdata[i];
        end
        if (bvalid[i] && bready[i]) begin
          have_aw[i] <= 1'b0;
          have_w[i]  <= 1'b0;
          mem[i][aw_a[i][AB-1:2]] <= w_d[i];
          wr_n[i] <= wr_n[i] + 1;
        end
        if (arvalid[i] && arready[i]) begin
          have_ar[i] <= 1'b1;
          ar_a[i]    <= araddr[i];
        end
        if (rvalid[i] && rready[i]) begin
          have_ar[i] <= 1'b0;
          rd_n[i]    <= rd_n[i] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic fail(input string name);
    total_cnt++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: pops the scoreboard on every write response and checks protocol stability.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        aw_len[i]   = 0;
        w_len[i]    = 0;
        prev_awv[i] = 1'b0;
        prev_wv[i]  = 1'b0;
      end else begin
        if (awvalid[i]) aw_len[i]++;
        if (wvalid[i])  w_len[i]++;
        if (awvalid[i] && prev_awv[i]) check("awaddr_stable", 64'(awaddr[i]), 64'(prev_awaddr[i]));
        if (wvalid[i] && prev_wv[i])   check("wdata_stable", 64'(wdata[i]), 64'(prev_wdata[i]));
        if (awvalid[i] && awready[i]) last_aw[i] = awaddr[i];
        if (wvalid[i] && wready[i])   last_w[i]  = wdata[i];
        if (bvalid[i] && bready[i]) begin
          if (exp_q[i].size() == 0) begin
            fail("unexpected_write");
          end else begin
            logic [63:0] e;
            e = exp_q[i].pop_front();
            check("write_addr", 64'(last_aw[i]), 64'(e[63:32]));
            check("write_data", 64'(last_w[i]), 64'(e[31:0]));
          end
          b_cnt[i]++;
          if (b_cnt[i] == 1) b_first[i] = cyc;
          b_last[i]      = cyc;
          aw_len_last[i] = aw_len[i];
          w_len_last[i]  = w_len[i];
          aw_len[i]      = 0;
          w_len[i]       = 0;
        end
        if (arvalid[i] && arready[i]) check("araddr_eq_awaddr", 64'(araddr[i]), 64'(last_aw[i]));
        if (done[i]) begin
          done_cnt[i]++;
          check("busy_low_in_done", 64'(busy[i]), 64'(0));
        end
        prev_awv[i]    = awvalid[i] && !awready[i];
        prev_wv[i]     = wvalid[i] && !wready[i];
        prev_awaddr[i] = awaddr[i];
        prev_wdata[i]  = wdata[i];
      end
    end
  end

  task automatic pulse_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Presents one word, waits for the handshake and then holds tvalid low for
  // gap cycles; returns 1 in act if any write valid is seen once the DUT is back in FETCH.
  task automatic feed(input int i, input logic [31:0] w, input int gap, output bit act);
    int n;
    act = 1'b0;
    tvalid[i] = 1'b1;
    tdata[i]  = w;
    n = 0;
    while (!tready[i] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("stream_handshake");
    @(negedge clk);
    if (gap > 0) begin
      tvalid[i] = 1'b0;
      for (int g = 0; g < gap; g++) begin
        if (g >= 3 && (awvalid[i] || wvalid[i])) act = 1'b1;
        start[i] = (g == 1);
        @(negedge clk);
      end
      start[i] = 1'b0;
    end
  endtask

  task automatic run_load(input int i, input logic [31:0] base, input int gap);
    int d0, b0, n;
    bit act, any_act;
    d0 = done_cnt[i];
    b0 = b_cnt[i];
    any_act = 1'b0;
    pulse_start(i);
    check("error_cleared_by_start", 64'(error[i]), 64'(0));
    for (int k = 0; k < NW; k++) begin
      // With PE=2 the (fold, lane) pair packs back into c, so addr = c*16 + t*4.
      exp_q[i].push_back({32'((k / TC) * 16 + (k % TC) * 4), base + 32'(k)});
      feed(i, base + 32'(k), gap, act);
      any_act |= act;
    end
    tvalid[i] = 1'b0;
    n = 0;
    while (done_cnt[i] == d0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("done_once", 64'(done_cnt[i] - d0), 64'(1));
    check("write_count", 64'(b_cnt[i] - b0), 64'(NW));
    check("scoreboard_drained", 64'(exp_q[i].size()), 64'(0));
    if (gap > 0) check("idle_during_gaps", 64'(any_act), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      aw_wait[i]  = 0;
      err_idx[i]  = -1;
      cor_idx[i]  = -1;
      cor_mask[i] = 32'h0;
      done_cnt[i] = 0;
      b_cnt[i]    = 0;
      tdata[i]    = 32'h0;
    end
    rst    = 1'b1;
    start  = 2'b00;
    tvalid = 2'b00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check("reset_outputs",
            64'({busy[i], done[i], error[i], tready[i], awvalid[i], wvalid[i], bready[i], arvalid[i], rready[i]}),
            64'(0));
    rst = 1'b0;
    @(negedge clk);

    // zero-wait responder, 12 writes in order, 4 cycles per threshold
    run_load(0, 32'h0, 0);
    check("t1_error", 64'(error[0]), 64'(0));
    check("t1_last_awaddr", 64'(last_aw[0]), 64'h38);
    check("t1_last_wdata", 64'(last_w[0]), 64'd11);
    check("t1_throughput", 64'(b_last[0] - b_first[0]), 64'(4 * (NW - 1)));

    // AWREADY late, WREADY immediate
    aw_wait[0] = 2;
    run_load(0, 32'h100, 0);
    check("t2_awvalid_cycles", 64'(aw_len_last[0]), 64'd3);
    check("t2_wvalid_cycles", 64'(w_len_last[0]), 64'd1);
    check("t2_error", 64'(error[0]), 64'(0));
    aw_wait[0] = 0;

    // SLVERR on the 5th write: sticky error, load still completes
    err_idx[0] = 4;
    run_load(0, 32'h200, 0);
    check("t3_error_set", 64'(error[0]), 64'(1));
    repeat (3) @(negedge clk);
    check("t3_error_sticky", 64'(error[0]), 64'(1));
    err_idx[0] = -1;

    // stream gaps with start pulses while busy; start clears the old error
    run_load(0, 32'h300, 5);
    check("t5_error", 64'(error[0]), 64'(0));

    // readback mismatch in bit 3 at c=2, t=1 (8th location)
    cor_idx[1]  = 7;
    cor_mask[1] = 32'h8;
    run_load(1, 32'h40, 0);
    check("t4_bit3_error", 64'(error[1]), 64'(1));
    cor_mask[1] = 32'h4000_0000;
    run_load(1, 32'h80, 0);
    check("t4_bit30_no_error", 64'(error[1]), 64'(0));

    // reset while stuck in WRITE
    aw_wait[0] = 20;
    pulse_start(0);
    begin
      bit dummy;
      feed(0, 32'hAB, 0, dummy);
    end
    tvalid[0] = 1'b0;
    @(negedge clk);
    check("t6_in_write", 64'({awvalid[0], wvalid[0]}), 64'b10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_after_reset", 64'({awvalid[0], wvalid[0], bready[0], busy[0]}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    aw_wait[0] = 0;
    exp_q[0].delete();
    run_load(0, 32'h500, 0);
    check("t6_reload_error", 64'(error[0]), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
